// File: rtl/dht11_responder.sv
// dht11_responder: sensor side of the DHT11 single-wire protocol.
// Waits for a host start pulse of at least START_MIN_US, then answers with the
// response preamble (80us low, 80us high) and a 40-bit frame, MSB first:
// hum_int, hum_dec, temp_int, temp_dec, checksum.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   dq_i          sensed level of the open-drain line (asynchronous)
//   hum_int_i     humidity integer byte
//   hum_dec_i     humidity decimal byte
//   temp_int_i    temperature integer byte
//   temp_dec_i    temperature decimal byte
//   fault_inj_i   (only with DHT11_FAULT_INJ_EN) flip checksum bit 0 of the frame
//   dq_oe_o       1 = pull line low, 0 = release
//   busy_o        high from start acceptance until back in idle
//   done_o        one-cycle pulse on frame completion
//   err_o         one-cycle pulse on collision abort
//
// Configuration: define DHT11_FAULT_INJ_EN to add fault_inj_i, which is sampled at
// the frame latch and corrupts the transmitted checksum (chk ^ 8'h01).
module dht11_responder #(
    parameter int unsigned CLK_HZ       = 1000000,
    parameter int unsigned START_MIN_US = 18000,
    parameter int unsigned WAIT_US      = 30,
    parameter int unsigned RESP_LOW_US  = 80,
    parameter int unsigned RESP_HIGH_US = 80,
    parameter int unsigned BIT_LOW_US   = 50,
    parameter int unsigned ZERO_HIGH_US = 26,
    parameter int unsigned ONE_HIGH_US  = 70
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       dq_i,
    input  logic [7:0] hum_int_i,
    input  logic [7:0] hum_dec_i,
    input  logic [7:0] temp_int_i,
    input  logic [7:0] temp_dec_i,
`ifdef DHT11_FAULT_INJ_EN
    input  logic       fault_inj_i,
`endif
    output logic       dq_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    function automatic logic [31:0] us2cyc(input logic [63:0] us);
        logic [63:0] c;
        c = (us * 64'(CLK_HZ)) / 64'd1000000;
        return c[31:0];
    endfunction

    localparam logic [31:0] NStart    = us2cyc(64'(START_MIN_US));
    localparam logic [31:0] NWait     = us2cyc(64'(WAIT_US));
    localparam logic [31:0] NRespLow  = us2cyc(64'(RESP_LOW_US));
    localparam logic [31:0] NRespHigh = us2cyc(64'(RESP_HIGH_US));
    localparam logic [31:0] NBitLow   = us2cyc(64'(BIT_LOW_US));
    localparam logic [31:0] NZero     = us2cyc(64'(ZERO_HIGH_US));
    localparam logic [31:0] NOne      = us2cyc(64'(ONE_HIGH_US));

    typedef enum logic [3:0] {
        StIdle, StWaitLow, StWaitRel, StWait, StRespLow,
        StRespHigh, StBitLow, StBitHigh, StEndLow
    } state_e;

    state_e      state_q, state_d;
    logic        dq_meta_q, dq_s_q;
    logic [31:0] cnt_q, cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic        rearm_q, rearm_d;
    logic        dq_oe_q, dq_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  chk;
    logic        fault;
    logic        collide;

`ifdef DHT11_FAULT_INJ_EN
    assign fault = fault_inj_i;
`else
    assign fault = 1'b0;
`endif

    // 8-bit context: the sum wraps mod 256
    assign chk = hum_int_i + hum_dec_i + temp_int_i + temp_dec_i;

    // First 3 cycles of a released phase are skipped: our own low is still in the synchronizer
    assign collide = (cnt_q >= 32'd3) && !dq_s_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        rearm_d   = rearm_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // Re-arm once the line has been seen high again after a frame or abort
        if (dq_s_q) rearm_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!dq_s_q && !rearm_q) state_d = StWaitLow;
            end
            StWaitLow: begin
                // The idle cycle that saw the falling level counts as the first low cycle
                if (dq_s_q) state_d = StIdle;
                else if (cnt_q + 32'd2 >= NStart) state_d = StWaitRel;
            end
            StWaitRel: begin
                if (dq_s_q) begin
                    shift_d   = {hum_int_i, hum_dec_i, temp_int_i, temp_dec_i,
                                 chk ^ {7'd0, fault}};
                    bit_idx_d = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (cnt_q == NWait - 32'd1) state_d = StRespLow;
            end
            StRespLow: begin
                if (cnt_q == NRespLow - 32'd1) state_d = StRespHigh;
            end
            StRespHigh: begin
                if (collide) begin
                    err_d   = 1'b1;
                    rearm_d = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == NRespHigh - 32'd1) begin
                    state_d = StBitLow;
                end
            end
            StBitLow: begin
                if (cnt_q == NBitLow - 32'd1) state_d = StBitHigh;
            end
            StBitHigh: begin
                if (collide) begin
                    err_d   = 1'b1;
                    rearm_d = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == (shift_q[39] ? NOne : NZero) - 32'd1) begin
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_idx_d = bit_idx_q + 6'd1;
                    state_d   = (bit_idx_q == 6'd39) ? StEndLow : StBitLow;
                end
            end
            StEndLow: begin
                if (cnt_q == NBitLow - 32'd1) begin
                    done_d  = 1'b1;
                    rearm_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cnt_d   = (state_d != state_q) ? '0 : cnt_q + 32'd1;
        // Outputs are registered from the next state so they stay glitch-free
        dq_oe_d = (state_d == StRespLow) || (state_d == StBitLow) || (state_d == StEndLow);
        busy_d  = (state_d != StIdle) && (state_d != StWaitLow);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dq_meta_q <= 1'b1;
            dq_s_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            rearm_q   <= 1'b0;
            dq_oe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dq_meta_q <= dq_i;
            dq_s_q    <= dq_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            rearm_q   <= rearm_d;
            dq_oe_q   <= dq_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign dq_oe_o = dq_oe_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: directed sequence with random payloads for dht11_responder.
// The line is modelled as a wired-AND of host, forced collision and DUT drive; the
// host follows the DUT otherwise. Frames are decoded from dq_oe_o pulse widths and
// compared against the protocol timing and a checksum computed from the bytes.
module tb_dht11_responder;

    localparam int unsigned StartUs = 2000;  // shortened start pulse keeps runtime small
    localparam int WaitUs = 30, RespLowUs = 80, RespHighUs = 80;
    localparam int BitLowUs = 50, ZeroUs = 26, OneUs = 70;
    localparam int Limit = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_low = 1'b0;
    logic       force_low = 1'b0;
    logic       fault_inj = 1'b0;
    logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
    logic       dq;
    logic       dq_oe_o, busy_o, done_o, err_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, busy_cyc = 0, oe_cyc = 0;

    assign dq = !(host_low || force_low || dq_oe_o);

    dht11_responder #(.START_MIN_US(StartUs)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .dq_i       (dq),
        .hum_int_i  (hum_int),
        .hum_dec_i  (hum_dec),
        .temp_int_i (temp_int),
        .temp_dec_i (temp_dec),
`ifdef DHT11_FAULT_INJ_EN
        .fault_inj_i(fault_inj),
`endif
        .dq_oe_o    (dq_oe_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (err_o) err_cnt <= err_cnt + 1;
        if (busy_o) busy_cyc <= busy_cyc + 1;
        if (dq_oe_o) oe_cyc <= oe_cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts sampled cycles while dq_oe_o stays at lvl; returns at the first other level
    task automatic run_len(input logic lvl, output int len);
        len = 0;
        while (dq_oe_o === lvl && len < Limit) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic start_pulse(input int cycles);
        @(negedge clk);
        host_low = 1'b1;
        repeat (cycles) @(negedge clk);
        host_low = 1'b0;
    endtask

    // kind: 0 = complete frame, 1 = collision in bit abort_bit, 2 = reset in bit abort_bit
    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic fi, input int abort_bit,
                         input int kind);
        logic [7:0]  c;
        logic [39:0] exp, got;
        int          len, d0, e0;
        c   = 8'((int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256) ^ {7'd0, fi};
        exp = {b0, b1, b2, b3, c};
        got = '0;
        hum_int = b0; hum_dec = b1; temp_int = b2; temp_dec = b3; fault_inj = fi;
        d0 = done_cnt;
        e0 = err_cnt;
        start_pulse(int'(StartUs));
        // Release to first drive: wait phase plus 2-cycle synchronizer and 1 decision cycle
        len = 0;
        while (dq_oe_o !== 1'b1 && len < Limit) begin
            len++;
            @(negedge clk);
        end
        check("wait_len", 64'(len), 64'(WaitUs + 3));
        if (len >= Limit) return;
        // Payload is latched already: later input changes must not leak into the frame
        hum_int = 8'($urandom); temp_dec = 8'($urandom); fault_inj = 1'b0;
        run_len(1'b1, len);
        check("resp_low", 64'(len), 64'(RespLowUs));
        run_len(1'b0, len);
        check("resp_high", 64'(len), 64'(RespHighUs));
        if (len >= Limit) return;
        for (int i = 0; i < 40; i++) begin
            if (kind == 2 && i == abort_bit) begin
                check("pre_rst_oe", 64'(dq_oe_o), 64'd1);
                #1 rst_n = 1'b0;
                #1;
                check("rst_oe", 64'(dq_oe_o), 64'd0);
                check("rst_busy", 64'(busy_o), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (5) @(negedge clk);
                check("rst_no_done", 64'(done_cnt), 64'(d0));
                check("rst_no_err", 64'(err_cnt), 64'(e0));
                return;
            end
            run_len(1'b1, len);
            check("bit_low", 64'(len), 64'(BitLowUs));
            if (len >= Limit) return;
            if (kind == 1 && i == abort_bit) begin
                repeat (5) @(negedge clk);
                force_low = 1'b1;
                len = 0;
                while (err_o !== 1'b1 && len < 20) begin
                    len++;
                    @(negedge clk);
                end
                check("col_err", 64'(err_o), 64'd1);
                check("col_oe", 64'(dq_oe_o), 64'd0);
                check("col_busy", 64'(busy_o), 64'd0);
                repeat (10) @(negedge clk);
                force_low = 1'b0;
                repeat (10) @(negedge clk);
                check("col_err_cnt", 64'(err_cnt), 64'(e0 + 1));
                check("col_no_done", 64'(done_cnt), 64'(d0));
                check("col_idle", 64'(busy_o), 64'd0);
                return;
            end
            run_len(1'b0, len);
            check("bit_high", 64'(len), 64'(exp[39-i] ? OneUs : ZeroUs));
            if (len >= Limit) return;
            got[39-i] = (len > (ZeroUs + OneUs) / 2);
        end
        run_len(1'b1, len);
        check("end_low", 64'(len), 64'(BitLowUs));
        check("done_pulse", 64'(done_o), 64'd1);
        check("busy_end", 64'(busy_o), 64'd0);
        check("frame", 64'(got), 64'(exp));
        @(negedge clk);
        check("done_once", 64'(done_cnt), 64'(d0 + 1));
        check("no_err", 64'(err_cnt), 64'(e0));
    endtask

    initial begin
        int b0, o0;
        // Reset state
        #7;
        check("rst_oe", 64'(dq_oe_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", 64'(busy_o), 64'd0);

        // Short starts, including one cycle below the threshold
        b0 = busy_cyc; o0 = oe_cyc;
        start_pulse(int'(StartUs) / 2);
        repeat (20) @(negedge clk);
        start_pulse(int'(StartUs) - 1);
        repeat (60) @(negedge clk);
        check("short_busy", 64'(busy_cyc), 64'(b0));
        check("short_oe", 64'(oe_cyc), 64'(o0));

        // Reference frame, checksum wrap, random payloads
        frame(8'h37, 8'h00, 8'h18, 8'h00, 1'b0, -1, 0);
        repeat (10) @(negedge clk);
        frame(8'hFF, 8'hFF, 8'hFF, 8'h03, 1'b0, -1, 0);
        for (int k = 0; k < 2; k++) begin
            repeat (10) @(negedge clk);
            frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1, 0);
        end

        // Collision during a bit high phase
        repeat (10) @(negedge clk);
        frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
              int'($urandom_range(3, 30)), 1);

        // Reset during bit 12, then a full frame
        repeat (10) @(negedge clk);
        frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 12, 2);
        repeat (10) @(negedge clk);
        frame(8'h37, 8'h00, 8'h18, 8'h00, 1'b0, -1, 0);

`ifdef DHT11_FAULT_INJ_EN
        repeat (10) @(negedge clk);
        frame(8'h37, 8'h00, 8'h18, 8'h00, 1'b1, -1, 0);
`endif

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
